// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the ysyx_25040105 fetch unit.
//   ifu_state_t      : fetch FSM state encoding
//   INST_NOP         : addi x0, x0, 0, presented on fetch faults
//   RESET_PC_DEFAULT : boot address
package ysyx_25040105_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } ifu_state_t;

    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040105_Reg.sv
// Generic register with write enable and synchronous active-high reset.
//   clk, rst : clock, synchronous reset (loads RESET_VAL)
//   wen      : load din on the next rising edge
//   din/dout : data in / registered data out
module ysyx_25040105_Reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    always_comb begin
        dout_d = wen ? din : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: holds the PC, issues one read per instruction and
// hands {pc, inst, fault} to decode through a valid/ready handshake.
//   imem_req_*  : read request (address is always the current PC)
//   imem_resp_* : single-cycle response pulse with data and error flag
//   out_*       : instruction presented to the IDU
//   redirect_*  : PC load from execute/writeback, priority below rst only
module ysyx_25040105_ifu
    import ysyx_25040105_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ifu_state_t  state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        drop_q, drop_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_we;
    logic        req_valid_c;
    logic        out_valid_c;

    ysyx_25040105_Reg #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .wen  (pc_we),
        .din  (pc_d),
        .dout (pc_q)
    );

    // Next-state, datapath updates and handshake qualifiers.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        fault_d     = fault_q;
        drop_d      = drop_q;
        pc_d        = pc_q;
        pc_we       = 1'b0;
        req_valid_c = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (pc_q[1:0] == 2'b00) begin
                    req_valid_c = !redirect_valid;
                    if (req_valid_c && imem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end else if (!redirect_valid) begin
                    // Misaligned: skip the bus and present a faulted NOP.
                    inst_d  = INST_NOP;
                    fault_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        // Stale response for a PC that has been redirected away.
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d  = imem_resp_err ? INST_NOP : imem_resp_data;
                        fault_d = imem_resp_err;
                        state_d = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_OUT: begin
                out_valid_c = !redirect_valid;
                if (out_valid_c && out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    pc_we   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides the PC update; outside WAIT it restarts fetch.
        if (redirect_valid) begin
            pc_d  = redirect_pc;
            pc_we = 1'b1;
            if (state_q != ST_WAIT) begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            inst_q  <= INST_NOP;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are forced to their reset view while rst is asserted, since the
    // synchronous reset has not yet reached the registers in that cycle.
    assign imem_req_valid = req_valid_c && !rst;
    assign out_valid      = out_valid_c && !rst;
    assign imem_req_addr  = pc_q;
    assign out_pc         = rst ? RESET_PC : pc_q;
    assign out_inst       = rst ? INST_NOP : inst_q;
    assign out_fault      = fault_q && !rst;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
module tb_ysyx_25040105_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040105_ifu #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_fault       (out_fault),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        re;
        logic        ordy;
        logic        xv;
        logic [31:0] xpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_i, input logic rdy, input logic rv, input logic [31:0] rd,
        input logic re, input logic ordy, input logic xv, input logic [31:0] xpc,
        input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
        input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_f);
        vec_t v;
        v.rst = rst_i; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re;
        v.ordy = ordy; v.xv = xv; v.xpc = xpc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %08h expected %08h", tag, nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check outputs.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst             = v.rst;
        imem_req_ready  = v.rdy;
        imem_resp_valid = v.rv;
        imem_resp_data  = v.rd;
        imem_resp_err   = v.re;
        out_ready       = v.ordy;
        redirect_valid  = v.xv;
        redirect_pc     = v.xpc;
        #1;
        chk(tag, "req_valid", 32'(imem_req_valid), 32'(v.e_rv));
        chk(tag, "out_valid", 32'(out_valid), 32'(v.e_ov));
        if (v.e_rv) chk(tag, "req_addr", imem_req_addr, v.e_addr);
        if (v.e_ov || v.rst) begin
            chk(tag, "out_pc", out_pc, v.e_pc);
            chk(tag, "out_inst", out_inst, v.e_inst);
            chk(tag, "out_fault", 32'(out_fault), 32'(v.e_f));
        end
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; imem_resp_err = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        //          rst rdy rv data          re ordy xv xpc            e_rv addr           e_ov pc             inst           f
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0,         0, RPC,           NOP,           0)); // reset
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0)); // IDLE
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0,         32'h0,         0)); // REQ
        tbl.push_back(mk(0, 1, 1, 32'h0010_0093,0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0)); // WAIT
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0000, 32'h0010_0093, 0)); // OUT
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0004, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 1, 32'h0020_0113,0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0004, 32'h0020_0113, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h0,         32'h0,         0)); // req stall
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 1, 32'h1234_5678,1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0)); // bus error
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0008, NOP,           1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_000C, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0180, 0, 32'h0,         0, 32'h0,         32'h0,         0)); // redirect in WAIT
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0100, 0, 32'h0,         0, 32'h0,         32'h0,         0)); // last one wins
        tbl.push_back(mk(0, 1, 1, 32'hDEAD_BEEF,0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0)); // stale dropped
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 1, 32'h0000_0033,0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0102, 0, 32'h0,         0, 32'h0,         32'h0,         0)); // redirect beats ready
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0)); // misaligned REQ
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0102, NOP,           1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0106, NOP,           1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0200, 0, 32'h0,         0, 32'h0,         32'h0,         0)); // redirect in REQ
        tbl.push_back(mk(0, 1, 1, 32'hBADB_AD00,0, 1, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         32'h0,         0)); // resp outside WAIT
        tbl.push_back(mk(0, 1, 1, 32'hAAAA_AAAA,0, 1, 1, 32'h8000_0300, 0, 32'h0,         0, 32'h0,         32'h0,         0)); // redirect + resp
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h8000_0300, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 1, 32'h0000_0513,0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0300, 32'h0000_0513, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // IDU backpressure: output held stable, no new request, PC frozen.
        apply(mk(0, 1, 0, 32'h0,         0, 0, 0, 32'h0, 1, 32'h8000_0304, 0, 32'h0, 32'h0, 0), "hold_req");
        apply(mk(0, 1, 1, 32'h00A0_0593, 0, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0, 32'h0, 0), "hold_resp");
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8000_0304, 32'h00A0_0593, 0),
                  $sformatf("hold%0d", k));
        end
        apply(mk(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0,         1, 32'h8000_0304, 32'h00A0_0593, 0), "hold_hs");
        apply(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h8000_0308, 0, 32'h0, 32'h0, 0), "hold_next");

        // PC wrap from the top of the address space.
        apply(mk(0, 0, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         32'h0,         0), "wrap_redir");
        apply(mk(0, 1, 0, 32'h0,         0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0), "wrap_req");
        apply(mk(0, 1, 1, 32'h0010_0073, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0), "wrap_resp");
        apply(mk(0, 1, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0010_0073, 0), "wrap_out");
        apply(mk(0, 1, 0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0,         0), "wrap_next");

        // Reset while WAIT; the late response must be ignored.
        apply(mk(1, 1, 0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,         0, RPC, NOP, 0), "rst_wait");
        apply(mk(0, 1, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'h0, 0, 32'h0,         0, 32'h0, 32'h0, 0), "rst_late");
        apply(mk(0, 1, 0, 32'h0,         0, 1, 0, 32'h0, 1, RPC,           0, 32'h0, 32'h0, 0), "rst_req");
        apply(mk(0, 1, 1, 32'h1111_1111, 0, 1, 0, 32'h0, 0, 32'h0,         0, 32'h0, 32'h0, 0), "rst_resp");
        apply(mk(0, 1, 0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,         1, RPC, 32'h1111_1111, 0), "rst_out");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
